axil_reg_bank: RTL
==================

# axil_reg_bank

AXI4-Lite slave register bank: a generalised, parametrised successor to the plain AXI-Lite slave port bundle. It terminates an AXI4-Lite slave port and exposes `REG_NUM` memory-mapped registers to fabric logic. Each register is either read/write control or read-only status. Write address and write data channels are accepted independently, and byte strobes are honoured. Typical placement is the control/status port of a stream converter or DMA-style block.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, default 32: data width; 32 or 64.
- `AXI_ADDR_WIDTH`, default 32: address width.
- `REG_NUM`, default 16: number of registers, 1..256.
- `RO_MASK`, default 0 (`REG_NUM` bits): bit i = 1 makes register i read-only. Its read value is `reg_in` slice i.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_axil_awaddr` in `AXI_ADDR_WIDTH`, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in `AXI_DATA_WIDTH`, `s_axil_wstrb` in `AXI_DATA_WIDTH/8`, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response channel.
- `s_axil_araddr` in `AXI_ADDR_WIDTH`, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address channel.
- `s_axil_rdata` out `AXI_DATA_WIDTH`, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data channel.
- `reg_out` out `REG_NUM*AXI_DATA_WIDTH`: current value of every R/W register. Slice i is register i. RO slices are 0.
- `reg_in` in `REG_NUM*AXI_DATA_WIDTH`: status values for RO registers. Slices for R/W registers are ignored.
- `wr_pulse` out `REG_NUM`: one-cycle strobe on bit i when R/W register i is written.

## Operation
- Address decode:
  - `idx = addr >> log2(AXI_DATA_WIDTH/8)`; the low byte-offset bits are ignored.
  - The address is in range iff `idx < REG_NUM`.
- Write path:
  - State is two holding flags, `aw_held` and `w_held`, plus `bvalid`.
  - `awready = !aw_held && !bvalid`. `wready = !w_held && !bvalid`.
  - AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - Commit happens on the edge where both are available, either held or handshaking that edge. At that edge:
    - Bytes with `wstrb[k] = 1` update the register, if it is R/W and in range.
    - `wr_pulse[idx]` is set for exactly one cycle, only for a writable in-range target.
    - Both held flags clear and `bvalid` sets.
- Write response:
  - `bvalid` holds until `bready`.
  - No new AW or W is accepted while `bvalid` is 1.
  - `bresp` = OKAY for RO targets; writes to them are silently dropped.
  - `wstrb = 0` is a legal no-op write: it returns OKAY and still pulses `wr_pulse`.
- Read path:
  - Two states, R_IDLE and R_RESP. `arready = (state == R_IDLE)`.
  - On AR handshake: move to R_RESP and register `rdata`. R/W targets return the register value; RO targets return the `reg_in` slice sampled that edge.
  - R_RESP holds until `rready`, then returns to R_IDLE.
- Read and write paths are fully independent. A read and a commit to the same register on the same edge returns the pre-write value.

## Timing
- Reset (asynchronous, `aresetn = 0`):
  - All registers, `reg_out`, `wr_pulse`, `bvalid`, `rvalid`, `bresp`, `rresp` and `rdata` are 0.
  - `awready`, `wready` and `arready` are 0 during reset and rise at the first `aclk` edge after deassertion.
- Latency:
  - With AW and W handshaking at edge N, `bvalid` and the register update are visible after edge N.
  - An AR handshake at edge N gives `rvalid` after edge N.
  - Back-to-back throughput is one write per 2 cycles and one read per 2 cycles when `bready`/`rready` are held 1.
- Reset asserted mid-transaction aborts it: held AW/W are discarded and no response is issued.
- All outputs are registered except the ready signals, which are decoded from registered state.

## Configuration
- `AXIL_REG_BANK_ERR_EN` defined:
  - Out-of-range accesses return SLVERR (`2'b10`) on `bresp`/`rresp`.
  - Out-of-range reads return `rdata = 0`.
- Macro undefined:
  - Out-of-range accesses return OKAY.
  - Writes are dropped and reads return 0.
- In-range behaviour is identical in both builds.

## Test plan
- Reset, then AW and W in the same cycle: addr 0x4, data 0xDEADBEEF, strb 0xF -> `bvalid` one cycle later, `bresp` OKAY, `reg_out` slice 1 = 0xDEADBEEF, `wr_pulse` = 0x0002 for one cycle.
- W leads AW by 3 cycles, addr 0x8, strb 0x3, data 0x12345678, prior value 0xAAAAAAAA -> `wready` falls after W handshake, register 2 = 0xAAAA5678.
- `RO_MASK` = 0x0008, `reg_in` slice 3 = 0x55; write 0xFF to 0xC, then read 0xC -> write OKAY, no `wr_pulse`; read `rdata` = 0x55, OKAY.
- `bready` held 0 for 5 cycles after a write -> `bvalid` stays 1, `bresp` stable, `awready`/`wready` stay 0; a concurrent read of 0x4 still completes.
- Read of 0x40 with `REG_NUM` = 16 -> `rresp` = SLVERR and `rdata` = 0 with `AXIL_REG_BANK_ERR_EN`; OKAY and 0 without it.
- `aresetn` pulsed low after AW handshake but before W -> no `bvalid`; all registers 0; the next full write completes normally.

Source files
------------

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: REG_NUM registers, each R/W control or RO status (RO_MASK).
// Define AXIL_REG_BANK_ERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
//
// Read FSM:
//   state  | meaning
//   R_IDLE | accepting a read address (arready = 1)
//   R_RESP | rdata/rresp valid, waiting for rready
module axil_reg_bank #(
  parameter int                 AXI_DATA_WIDTH = 32,
  parameter int                 AXI_ADDR_WIDTH = 32,
  parameter int                 REG_NUM        = 16,
  parameter logic [REG_NUM-1:0] RO_MASK        = '0
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axil_awaddr,
  input  logic                              s_axil_awvalid,
  output logic                              s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]         s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]       s_axil_wstrb,
  input  logic                              s_axil_wvalid,
  output logic                              s_axil_wready,
  output logic [1:0]                        s_axil_bresp,
  output logic                              s_axil_bvalid,
  input  logic                              s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axil_araddr,
  input  logic                              s_axil_arvalid,
  output logic                              s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]         s_axil_rdata,
  output logic [1:0]                        s_axil_rresp,
  output logic                              s_axil_rvalid,
  input  logic                              s_axil_rready,
  output logic [REG_NUM*AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [REG_NUM*AXI_DATA_WIDTH-1:0] reg_in,
  output logic [REG_NUM-1:0]                wr_pulse
);
  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_BANK_ERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  logic                      ready_en_q, ready_en_d;
  logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [REG_NUM-1:0]        wr_pulse_q, wr_pulse_d;
  logic [AXI_DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [AXI_DATA_WIDTH-1:0] regs_d [REG_NUM];
  logic [0:0]                r_state_q, r_state_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic                      aw_hs, w_hs, ar_hs, commit, wr_in_range;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;

  // Readies stay low until the first edge after reset release.
  assign s_axil_awready = ready_en_q && !aw_held_q && !bvalid_q;
  assign s_axil_wready  = ready_en_q && !w_held_q && !bvalid_q;
  assign s_axil_arready = ready_en_q && (r_state_q == R_IDLE);
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = (r_state_q == R_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign wr_pulse       = wr_pulse_q;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (!RO_MASK[i]) reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[i];
    end
  end

  always_comb begin
    ready_en_d = 1'b1;
    aw_hs      = s_axil_awvalid && s_axil_awready;
    w_hs       = s_axil_wvalid && s_axil_wready;
    wr_addr    = aw_held_q ? awaddr_q : s_axil_awaddr;
    wr_data    = w_held_q ? wdata_q : s_axil_wdata;
    wr_strb    = w_held_q ? wstrb_q : s_axil_wstrb;
    wr_idx     = wr_addr >> ADDR_LSB;
    commit     = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end

    wr_in_range = 1'b0;
    wr_pulse_d  = '0;
    regs_d      = regs_q;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wr_idx == AXI_ADDR_WIDTH'(i)) begin
        wr_in_range = 1'b1;
        if (commit && !RO_MASK[i]) begin
          wr_pulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (wr_strb[k]) regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
          end
        end
      end
    end

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_OOR;
    end
  end

  // Reads sample regs_q, so a same-edge commit is not yet visible.
  always_comb begin
    ar_hs     = s_axil_arvalid && s_axil_arready;
    rd_idx    = s_axil_araddr >> ADDR_LSB;
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rdata_d   = '0;
          rresp_d   = RESP_OOR;
          for (int i = 0; i < REG_NUM; i++) begin
            if (rd_idx == AXI_ADDR_WIDTH'(i)) begin
              rresp_d = RESP_OKAY;
              rdata_d = RO_MASK[i] ? reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : regs_q[i];
            end
          end
        end
      end
      R_RESP: begin
        if (s_axil_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      r_state_q  <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      r_state_q  <= r_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end
endmodule
